aes_encrypt_core: RTL and testbench

//  Iterative AES-128 encryption datapath, one round per clock. Sits directly

---
 rtl/aes_encrypt_core_if.sv | 38 +++
 rtl/aes_encrypt_core.sv | 205 ++++++++++++++++++++
 tb/tb_aes_encrypt_core.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_encrypt_core_if.sv
// Handshake and data bundle between the AES encryption core and its client.
// The master side supplies plaintext, start/keyValid and the 11 round keys
// from the key-expansion block; the slave side returns ciphertext and status.
interface aes_encrypt_core_if;
    logic         start;
    logic         keyValid;
    logic [127:0] plainTextInput;
    logic [127:0] roundKeyInput0;
    logic [127:0] roundKeyInput1;
    logic [127:0] roundKeyInput2;
    logic [127:0] roundKeyInput3;
    logic [127:0] roundKeyInput4;
    logic [127:0] roundKeyInput5;
    logic [127:0] roundKeyInput6;
    logic [127:0] roundKeyInput7;
    logic [127:0] roundKeyInput8;
    logic [127:0] roundKeyInput9;
    logic [127:0] roundKeyInput10;
    logic [127:0] cipherTextOutput;
    logic         busy;
    logic         done;

    modport master (
        output start, keyValid, plainTextInput,
               roundKeyInput0, roundKeyInput1, roundKeyInput2, roundKeyInput3,
               roundKeyInput4, roundKeyInput5, roundKeyInput6, roundKeyInput7,
               roundKeyInput8, roundKeyInput9, roundKeyInput10,
        input  cipherTextOutput, busy, done
    );

    modport slave (
        input  start, keyValid, plainTextInput,
               roundKeyInput0, roundKeyInput1, roundKeyInput2, roundKeyInput3,
               roundKeyInput4, roundKeyInput5, roundKeyInput6, roundKeyInput7,
               roundKeyInput8, roundKeyInput9, roundKeyInput10,
        output cipherTextOutput, busy, done
    );
endinterface

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock.
// Edge T accepts the block (initial AddRoundKey), edges T+1..T+9 run the
// full rounds, edge T+10 runs the final round (no MixColumns) and pulses done.
// Round keys come straight from the key-expansion block and are muxed by the
// round counter, so they must stay stable for the whole encryption.
module aes_encrypt_core #(
    parameter int numRounds = 10   // only AES-128 (10 rounds) is supported
) (
    input  logic                 clock,
    input  logic                 reset,
    aes_encrypt_core_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } fsm_state_t;

    localparam logic [3:0] LAST_FULL_ROUND = 4'(numRounds - 1);

    // Forward S-box, FIPS-197, indexed by the input byte.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte k of the state lives at [127-8k -: 8]; row = k%4, column = k/4.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int k = 0; k < 16; k++) begin
            r[127-8*k -: 8] = SBOX[s[127-8*k -: 8]];
        end
        return r;
    endfunction

    // Row r of the output takes its byte from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        int           row;
        int           col;
        int           src;
        r = 128'h0;
        for (int k = 0; k < 16; k++) begin
            row = k % 4;
            col = k / 4;
            src = 4 * ((col + row) % 4) + row;
            r[127-8*k -: 8] = s[127-8*src -: 8];
        end
        return r;
    endfunction

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Each column times the circulant [02 03 01 01].
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    fsm_state_t   fsm_r;
    fsm_state_t   fsm_next_s;
    logic         load_s;
    logic         round_s;
    logic         final_s;
    logic [3:0]   counter_r;
    logic [127:0] state_r;
    logic [127:0] cipher_r;
    logic         busy_r;
    logic         done_r;
    logic [127:0] round_key_s;
    logic [127:0] shifted_s;
    logic [127:0] mixed_s;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_r <= IDLE;
        end else begin
            fsm_r <= fsm_next_s;
        end
    end

    // Next-state decode and datapath step selection.
    always_comb begin
        fsm_next_s = fsm_r;
        load_s     = 1'b0;
        round_s    = 1'b0;
        final_s    = 1'b0;
        case (fsm_r)
            IDLE: begin
                // keyValid only matters at acceptance; a start without it is dropped
                if (bus.start && bus.keyValid) begin
                    load_s     = 1'b1;
                    fsm_next_s = ROUND;
                end else begin
                    fsm_next_s = IDLE;
                end
            end
            ROUND: begin
                round_s = 1'b1;
                if (counter_r == LAST_FULL_ROUND) begin
                    fsm_next_s = FINAL;
                end else begin
                    fsm_next_s = ROUND;
                end
            end
            FINAL: begin
                final_s    = 1'b1;
                fsm_next_s = IDLE;
            end
            default: begin
                fsm_next_s = IDLE;
            end
        endcase
    end

    // Round-key mux for the full rounds 1..9.
    always_comb begin
        round_key_s = 128'h0;
        case (counter_r)
            4'd1:    round_key_s = bus.roundKeyInput1;
            4'd2:    round_key_s = bus.roundKeyInput2;
            4'd3:    round_key_s = bus.roundKeyInput3;
            4'd4:    round_key_s = bus.roundKeyInput4;
            4'd5:    round_key_s = bus.roundKeyInput5;
            4'd6:    round_key_s = bus.roundKeyInput6;
            4'd7:    round_key_s = bus.roundKeyInput7;
            4'd8:    round_key_s = bus.roundKeyInput8;
            4'd9:    round_key_s = bus.roundKeyInput9;
            default: round_key_s = 128'h0;
        endcase
    end

    // Shared SubBytes/ShiftRows feeds both the full rounds and the final round.
    always_comb begin
        shifted_s = shift_rows(sub_bytes(state_r));
        mixed_s   = mix_columns(shifted_s);
    end

    // Datapath registers: state, round counter, ciphertext and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= 128'h0;
            counter_r <= 4'd0;
            cipher_r  <= 128'h0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= final_s;
            if (load_s) begin
                state_r   <= bus.plainTextInput ^ bus.roundKeyInput0;
                counter_r <= 4'd1;
                busy_r    <= 1'b1;
            end else if (round_s) begin
                state_r   <= mixed_s ^ round_key_s;
                counter_r <= counter_r + 4'd1;
            end else if (final_s) begin
                cipher_r  <= shifted_s ^ bus.roundKeyInput10;
                counter_r <= 4'd0;
                busy_r    <= 1'b0;
            end else begin
                state_r   <= state_r;
            end
        end
    end

    assign bus.cipherTextOutput = cipher_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed testbench for aes_encrypt_core using FIPS-197 known-answer vectors.
// Round keys are produced by a small key-expansion model standing in for the
// upstream block; expected ciphertexts are the published constants.
module tb_aes_encrypt_core;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    aes_encrypt_core_if bus ();

    aes_encrypt_core #(.numRounds(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [0:255][7:0] TB_SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] PT_BAD = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {TB_SBOX[w[31:24]], TB_SBOX[w[23:16]], TB_SBOX[w[15:8]], TB_SBOX[w[7:0]]};
    endfunction

    // Model of the upstream key expansion: drives all 11 round-key ports.
    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        bus.roundKeyInput0  = {w[0],  w[1],  w[2],  w[3]};
        bus.roundKeyInput1  = {w[4],  w[5],  w[6],  w[7]};
        bus.roundKeyInput2  = {w[8],  w[9],  w[10], w[11]};
        bus.roundKeyInput3  = {w[12], w[13], w[14], w[15]};
        bus.roundKeyInput4  = {w[16], w[17], w[18], w[19]};
        bus.roundKeyInput5  = {w[20], w[21], w[22], w[23]};
        bus.roundKeyInput6  = {w[24], w[25], w[26], w[27]};
        bus.roundKeyInput7  = {w[28], w[29], w[30], w[31]};
        bus.roundKeyInput8  = {w[32], w[33], w[34], w[35]};
        bus.roundKeyInput9  = {w[36], w[37], w[38], w[39]};
        bus.roundKeyInput10 = {w[40], w[41], w[42], w[43]};
    endtask

    // One complete encryption: accept, latency, ciphertext, one-cycle done.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] exp_ct, input string name);
        int n;
        @(negedge clock);
        bus.plainTextInput = pt;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_after_start: got %b want 1", name, bus.busy);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges want 10", name, n);
        end
        checks++;
        if (bus.cipherTextOutput !== exp_ct) begin
            errors++;
            $display("FAIL %s_ct: got %h want %h", name, bus.cipherTextOutput, exp_ct);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done: got %b want 0", name, bus.busy);
        end
        @(negedge clock);
        checks++;
        if (bus.done !== 1'b0 || bus.cipherTextOutput !== exp_ct) begin
            errors++;
            $display("FAIL %s_done_width_hold: done=%b ct=%h want done=0 ct=%h",
                     name, bus.done, bus.cipherTextOutput, exp_ct);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.keyValid = 1'b0;
        bus.plainTextInput = 128'h0;
        set_key(128'h0);
        repeat (3) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cipherTextOutput !== 128'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b ct=%h want 0 0 0",
                     bus.busy, bus.done, bus.cipherTextOutput);
        end
        reset = 1'b0;
    endtask

    task automatic test_fips_b();
        set_key(KEY_B);
        bus.keyValid = 1'b1;
        run_block(PT_B, CT_B, "fips_b");
    endtask

    task automatic test_fips_c();
        set_key(KEY_C);
        bus.keyValid = 1'b1;
        run_block(PT_C, CT_C, "fips_c");
    endtask

    task automatic test_key_not_valid();
        int seen_busy;
        int seen_done;
        seen_busy = 0;
        seen_done = 0;
        set_key(KEY_B);
        bus.keyValid = 1'b0;
        bus.plainTextInput = PT_B;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            bus.start = 1'b1;
            if (bus.busy === 1'b1) seen_busy++;
            if (bus.done === 1'b1) seen_done++;
        end
        @(negedge clock);
        bus.start = 1'b0;
        if (bus.busy === 1'b1) seen_busy++;
        if (bus.done === 1'b1) seen_done++;
        checks++;
        if (seen_busy != 0 || seen_done != 0) begin
            errors++;
            $display("FAIL nokey_ignored: busy cycles=%0d done cycles=%0d want 0 0", seen_busy, seen_done);
        end
        bus.keyValid = 1'b1;
        run_block(PT_B, CT_B, "nokey_then_valid");
    endtask

    task automatic test_back_to_back();
        int n_done;
        int n;
        set_key(KEY_B);
        bus.keyValid = 1'b1;
        n_done = 0;
        @(negedge clock);
        bus.plainTextInput = PT_B;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            bus.start = (c == 3 || c == 7) ? 1'b1 : 1'b0;
            bus.plainTextInput = (c == 3 || c == 7) ? PT_BAD : PT_B;
            @(negedge clock);
            if (bus.done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 1 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_single_done: done count=%0d done_now=%b want 1 1", n_done, bus.done);
        end
        checks++;
        if (bus.cipherTextOutput !== CT_B) begin
            errors++;
            $display("FAIL b2b_first_ct: got %h want %h", bus.cipherTextOutput, CT_B);
        end
        // second block requested during the done cycle with a fresh key
        set_key(KEY_C);
        bus.plainTextInput = PT_C;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n != 10 || bus.cipherTextOutput !== CT_C) begin
            errors++;
            $display("FAIL b2b_second_ct: edges=%0d ct=%h want 10 %h", n, bus.cipherTextOutput, CT_C);
        end
    endtask

    task automatic test_reset_mid_op();
        int n_done;
        set_key(KEY_B);
        bus.keyValid = 1'b1;
        @(negedge clock);
        bus.plainTextInput = PT_B;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cipherTextOutput !== 128'h0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b done=%b ct=%h want 0 0 0",
                     bus.busy, bus.done, bus.cipherTextOutput);
        end
        n_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL midreset_no_done: active cycles=%0d want 0", n_done);
        end
        set_key(KEY_C);
        run_block(PT_C, CT_C, "after_reset");
    endtask

    task automatic test_all_zero();
        set_key(128'h0);
        bus.keyValid = 1'b1;
        run_block(128'h0, CT_Z, "all_zero");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fips_b();
        test_fips_c();
        test_key_not_valid();
        test_back_to_back();
        test_reset_mid_op();
        test_all_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
